// File: rtl/mm_match_ctrl.sv
// mm_match_ctrl -- matching-memory controller in front of MMRAM_Stage.
//
// Accepts operand packets from upstream, keeps a presence/tag/LR table that
// mirrors the 64-entry waiting RAM, and issues each packet downstream with the
// waiting-RAM index (ADDR) and the write/delete strobes (WR_E, DEL).
// Packets that collide with a different waiting operand are parked in a small
// retry FIFO and retried after a pair fires.
//
// Optional feature: define MMCTRL_COLL_CNT_EN to build the saturating
// collision counter on COLL_CNT; otherwise COLL_CNT is tied to zero.
//
// Ports
//   CP          clock, rising edge
//   MR          asynchronous active-high reset
//   Send_in     upstream packet valid (held with PACKET_IN until Ack_out)
//   Ack_out     one-cycle acceptance pulse to upstream
//   PACKET_IN   [37:27] tag, [26:20] dest, [19] LR, [18] MF, [17:16] C/Z, [15:0] data
//   Send_out    issued packet valid, held until Ack_in sampled high
//   Ack_in      downstream acceptance
//   PACKET_OUT  issued packet (bit-identical to the accepted one)
//   ADDR        waiting-RAM index, dest[5:0] of the issued packet
//   WR_E        write the issued packet into the waiting RAM
//   DEL         downstream absorbs the issued packet without output
//   COLL_FULL   retry FIFO full (registered, post-edge occupancy)
//   COLL_CNT    saturating collision count (zero unless MMCTRL_COLL_CNT_EN)
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | pick a candidate (FIFO head if retry pending, else upstream)
// ISSUE | Send_out high, outputs frozen until Ack_in

module mm_match_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CP,
    input  logic        MR,
    input  logic        Send_in,
    output logic        Ack_out,
    input  logic [37:0] PACKET_IN,
    output logic        Send_out,
    input  logic        Ack_in,
    output logic [37:0] PACKET_OUT,
    output logic [5:0]  ADDR,
    output logic        WR_E,
    output logic        DEL,
    output logic        COLL_FULL,
    output logic [15:0] COLL_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t      state_q, state_d;
    logic [63:0] pres_q, pres_d;
    logic [10:0] tag_q [64];
    logic        lr_q  [64];
    logic [37:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        retry_pend_q, retry_pend_d;
    logic        send_out_q, send_out_d;
    logic        ack_out_q, ack_out_d;
    logic [37:0] pkt_q, pkt_d;
    logic        wr_e_q, wr_e_d;
    logic        del_q, del_d;
    logic        coll_full_q, coll_full_d;

    logic        fifo_empty, fifo_full;
    logic        use_head, use_up;
    logic [37:0] cand;
    logic [5:0]  cand_addr;
    logic        tag_match, lr_diff;
    logic        cls_wait, cls_fire, cls_coll;
    logic        push, pop, tbl_set;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // While Ack_out is high the upstream packet just taken is still on the
    // bus; ignoring Send_in for that cycle prevents accepting it twice.
    assign use_head = (state_q == S_IDLE) && retry_pend_q && !fifo_empty;
    assign use_up   = (state_q == S_IDLE) && !use_head && Send_in && !ack_out_q;

    assign cand      = use_head ? fifo_mem[rd_ptr_q[AW-1:0]] : PACKET_IN;
    assign cand_addr = cand[25:20];
    assign tag_match = (tag_q[cand_addr] == cand[37:27]);
    assign lr_diff   = (lr_q[cand_addr] != cand[19]);
    assign cls_wait  = cand[18] && !pres_q[cand_addr];
    assign cls_fire  = cand[18] &&  pres_q[cand_addr] && tag_match && lr_diff;
    assign cls_coll  = cand[18] &&  pres_q[cand_addr] && !(tag_match && lr_diff);

    always_comb begin
        state_d      = state_q;
        pres_d       = pres_q;
        retry_pend_d = retry_pend_q;
        send_out_d   = send_out_q;
        ack_out_d    = 1'b0;
        pkt_d        = pkt_q;
        wr_e_d       = wr_e_q;
        del_d        = del_q;
        push         = 1'b0;
        pop          = 1'b0;
        tbl_set      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (use_head || use_up) begin
                    if (cls_coll) begin
                        if (use_head) begin
                            // Head still blocked: give upstream a turn.
                            retry_pend_d = 1'b0;
                        end else if (!fifo_full) begin
                            push      = 1'b1;
                            ack_out_d = 1'b1;
                        end
                    end else begin
                        state_d    = S_ISSUE;
                        send_out_d = 1'b1;
                        pkt_d      = cand;
                        wr_e_d     = cls_wait;
                        del_d      = cls_wait;
                        ack_out_d  = use_up;
                        if (use_head) begin
                            pop          = 1'b1;
                            retry_pend_d = 1'b0;
                        end
                        if (cls_wait) begin
                            pres_d[cand_addr] = 1'b1;
                            tbl_set           = 1'b1;
                        end
                        if (cls_fire) begin
                            pres_d[cand_addr] = 1'b0;
                            retry_pend_d      = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (Ack_in) begin
                    state_d    = S_IDLE;
                    send_out_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        coll_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_q      <= S_IDLE;
            pres_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            retry_pend_q <= 1'b0;
            send_out_q   <= 1'b0;
            ack_out_q    <= 1'b0;
            pkt_q        <= '0;
            wr_e_q       <= 1'b0;
            del_q        <= 1'b0;
            coll_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pres_q       <= pres_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            retry_pend_q <= retry_pend_d;
            send_out_q   <= send_out_d;
            ack_out_q    <= ack_out_d;
            pkt_q        <= pkt_d;
            wr_e_q       <= wr_e_d;
            del_q        <= del_d;
            coll_full_q  <= coll_full_d;
        end
    end

    // Tag/LR and FIFO payload are only meaningful under pres_q / the pointers,
    // so they carry no reset.
    always_ff @(posedge CP) begin
        if (tbl_set) begin
            tag_q[cand_addr] <= cand[37:27];
            lr_q[cand_addr]  <= cand[19];
        end
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= PACKET_IN;
        end
    end

`ifdef MMCTRL_COLL_CNT_EN
    logic        coll_event;
    logic [15:0] coll_cnt_q;

    // A stalled upstream collision (FIFO full) is re-evaluated every idle
    // cycle; it is counted once, when it is finally accepted.
    assign coll_event = (use_head && cls_coll) || (use_up && cls_coll && !fifo_full);

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            coll_cnt_q <= '0;
        end else if (coll_event && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign COLL_CNT = coll_cnt_q;
`else
    assign COLL_CNT = '0;
`endif

    assign Send_out   = send_out_q;
    assign Ack_out    = ack_out_q;
    assign PACKET_OUT = pkt_q;
    assign ADDR       = pkt_q[25:20];
    assign WR_E       = wr_e_q;
    assign DEL        = del_q;
    assign COLL_FULL  = coll_full_q;

endmodule

// File: tb/tb_mm_match_ctrl.sv
module tb_mm_match_ctrl;

    localparam int DEPTH = 4;

    logic        CP = 1'b0;
    logic        MR;
    logic        Send_in;
    logic        Ack_out;
    logic [37:0] PACKET_IN;
    logic        Send_out;
    logic        Ack_in;
    logic [37:0] PACKET_OUT;
    logic [5:0]  ADDR;
    logic        WR_E;
    logic        DEL;
    logic        COLL_FULL;
    logic [15:0] COLL_CNT;

    mm_match_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .CP(CP), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out),
        .PACKET_IN(PACKET_IN), .Send_out(Send_out), .Ack_in(Ack_in),
        .PACKET_OUT(PACKET_OUT), .ADDR(ADDR), .WR_E(WR_E), .DEL(DEL),
        .COLL_FULL(COLL_FULL), .COLL_CNT(COLL_CNT)
    );

    always #5 CP = ~CP;

    typedef struct packed {
        logic [37:0] pkt;
        logic        wr_e;
        logic        del;
    } exp_t;

    // Reference model: the partner waiting at each address, the retry queue,
    // and the expected issue stream.
    exp_t        exp_q[$];
    logic [37:0] waiting[int];
    logic [37:0] retry_q[$];
    int          coll_exp;
    int          n_cmp;
    int          n_bad;
    int          ack_mode;

    localparam int C_BYP = 0, C_WAIT = 1, C_FIRE = 2, C_COLL = 3;

    function automatic logic [37:0] mk(input int tag, input int dest, input bit lr,
                                       input bit mf, input int data);
        logic [10:0] t;
        logic [6:0]  d;
        logic [15:0] v;
        t = tag[10:0];
        d = dest[6:0];
        v = data[15:0];
        return {t, d, lr, mf, 2'b00, v};
    endfunction

    function automatic int classify(input logic [37:0] p);
        int a;
        a = int'(p[25:20]);
        if (!p[18]) return C_BYP;
        if (!waiting.exists(a)) return C_WAIT;
        if (waiting[a][37:27] == p[37:27] && waiting[a][19] != p[19]) return C_FIRE;
        return C_COLL;
    endfunction

    function automatic void bump_coll();
        if (coll_exp < 65535) coll_exp++;
    endfunction

    // After a pair fires, the retry queue head is tried; a head that fires
    // again keeps the chain going, a WAIT or a collision ends it.
    function automatic void drain();
        logic [37:0] h;
        int c;
        while (retry_q.size() > 0) begin
            h = retry_q[0];
            c = classify(h);
            if (c == C_COLL) begin
                bump_coll();
                break;
            end
            void'(retry_q.pop_front());
            if (c == C_WAIT) begin
                waiting[int'(h[25:20])] = h;
                exp_q.push_back({h, 1'b1, 1'b1});
                break;
            end
            waiting.delete(int'(h[25:20]));
            exp_q.push_back({h, 1'b0, 1'b0});
        end
    endfunction

    function automatic void apply(input logic [37:0] p, input int c);
        case (c)
            C_BYP:  exp_q.push_back({p, 1'b0, 1'b0});
            C_WAIT: begin
                waiting[int'(p[25:20])] = p;
                exp_q.push_back({p, 1'b1, 1'b1});
            end
            C_FIRE: begin
                waiting.delete(int'(p[25:20]));
                exp_q.push_back({p, 1'b0, 1'b0});
                drain();
            end
            default: begin
                retry_q.push_back(p);
                bump_coll();
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef MMCTRL_COLL_CNT_EN
        return coll_exp[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic do_reset();
        @(negedge CP);
        MR      = 1'b1;
        Send_in = 1'b0;
        waiting.delete();
        retry_q.delete();
        exp_q.delete();
        coll_exp = 0;
        @(negedge CP);
        MR = 1'b0;
        @(negedge CP);
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || Send_out) && k < 300) begin
            @(negedge CP);
            k++;
        end
        if (k >= 300) begin
            check("quiet_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge CP);
    endtask

    task automatic send(input logic [37:0] p);
        int  c;
        bit  stall;
        c     = classify(p);
        stall = (c == C_COLL) && (retry_q.size() == DEPTH);
        @(negedge CP);
        Send_in   = 1'b1;
        PACKET_IN = p;
        if (stall) begin
            check("stall_full", 64'(COLL_FULL), 64'd1);
            repeat (12) begin
                @(negedge CP);
                check("stall_no_ack", {62'd0, Ack_out, Send_out}, 64'd0);
            end
            do_reset();
            return;
        end
        @(negedge CP);
        check("ack_latency", 64'(Ack_out), 64'd1);
        check("send_latency", 64'(Send_out), (c == C_COLL) ? 64'd0 : 64'd1);
        Send_in = 1'b0;
        apply(p, c);
        @(negedge CP);
        check("ack_pulse", 64'(Ack_out), 64'd0);
        wait_quiet();
        check("coll_full", 64'(COLL_FULL), (retry_q.size() == DEPTH) ? 64'd1 : 64'd0);
        check("coll_cnt", 64'(COLL_CNT), 64'(exp_cnt()));
    endtask

    // Downstream acceptance.
    initial begin
        Ack_in = 1'b0;
        forever begin
            @(negedge CP);
            Ack_in = (ack_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // Monitor: every downstream handshake is checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CP);
            #2;
            if (!MR && Send_out && Ack_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", {26'd0, PACKET_OUT}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pkt", {26'd0, PACKET_OUT}, {26'd0, e.pkt});
                    check("issue_addr", 64'(ADDR), 64'(e.pkt[25:20]));
                    check("issue_wr_del", {62'd0, WR_E, DEL}, {62'd0, e.wr_e, e.del});
                end
            end
        end
    end

    initial begin
        logic [37:0] p;
        n_cmp     = 0;
        n_bad     = 0;
        coll_exp  = 0;
        ack_mode  = 0;
        MR        = 1'b1;
        Send_in   = 1'b0;
        PACKET_IN = '0;
        #1;
        check("reset_outs", {Send_out, Ack_out, WR_E, DEL, COLL_FULL, ADDR}, 64'd0);
        check("reset_pkt", {26'd0, PACKET_OUT}, 64'd0);
        check("reset_cnt", 64'(COLL_CNT), 64'd0);
        repeat (2) @(negedge CP);
        MR = 1'b0;

        // Bypass, then a matched pair at dest 9, then reuse of dest 9.
        send(mk(0, 5, 1'b0, 1'b0, 16'hA5A5));
        send(mk(3, 9, 1'b0, 1'b1, 16'h1111));
        send(mk(3, 9, 1'b1, 1'b1, 16'h2222));
        send(mk(7, 9, 1'b0, 1'b1, 16'h3333));
        do_reset();

        // Collision parked, then released by a fire.
        send(mk(3, 9, 1'b0, 1'b1, 16'h0001));
        send(mk(4, 9, 1'b0, 1'b1, 16'h0002));
        check("one_parked", 64'(retry_q.size() == 1 && COLL_CNT == exp_cnt()), 64'd1);
        send(mk(3, 9, 1'b1, 1'b1, 16'h0003));

        // Fill the retry FIFO at dest 9, then a further collision stalls.
        for (int i = 0; i < DEPTH; i++) send(mk(5, 9, 1'b0, 1'b1, 16'h0100 + i));
        send(mk(6, 9, 1'b0, 1'b1, 16'h0200));

        // Downstream holds off; outputs frozen, then MR mid-issue.
        ack_mode = 1;
        @(negedge CP);
        p = mk(2, 33, 1'b1, 1'b0, 16'hBEEF);
        Send_in   = 1'b1;
        PACKET_IN = p;
        @(negedge CP);
        Send_in = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) begin
            check("hold_ctrl", {61'd0, Send_out, WR_E, DEL}, 64'b100);
            check("hold_pkt", {26'd0, PACKET_OUT}, {26'd0, p});
            check("hold_addr", 64'(ADDR), 64'(p[25:20]));
            @(negedge CP);
        end
        #3;
        MR = 1'b1;
        #1;
        check("mr_async", {26'd0, Send_out, Ack_out, WR_E, DEL, COLL_FULL, ADDR, COLL_CNT}, 64'd0);
        check("mr_pkt", {26'd0, PACKET_OUT}, 64'd0);
        ack_mode = 0;
        do_reset();

        // Randomised traffic over a few contended addresses.
        for (int n = 0; n < 300; n++) begin
            int dsel;
            dsel = 9 + int'($urandom_range(0, 2)) + ($urandom_range(0, 1) == 1 ? 64 : 0);
            send(mk(int'($urandom_range(3, 4)), dsel, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 85), int'($urandom_range(0, 65535))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
